ldn_cn_accum: RTL and testbench

LDN_CN_ACCUM -- requirements
Module: ldn_cn_accum

---
 rtl/ariane_pkg.sv | 31 +++
 rtl/ldn_mag_sat.sv | 24 ++
 rtl/ldn_cn_accum.sv | 108 ++++++++++
 tb/tb_ldn_cn_accum.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ariane_pkg.sv
// Shared definitions for the LDN check-node datapath: default widths, FSM
// states and the min-sum update operator applied to each incoming magnitude.
package ariane_pkg;

  localparam int unsigned LDN_Q       = 8;
  localparam int unsigned LDN_DEG_MAX = 32;

  typedef enum logic [1:0] {
    LDN_IDLE,
    LDN_ACC,
    LDN_OUT
  } ldn_state_e;

  // Effect of one magnitude on the running (min1, min2) pair.
  typedef enum logic [1:0] {
    LDN_OP_KEEP,
    LDN_OP_NEW_MIN1,
    LDN_OP_NEW_MIN2
  } ldn_op_e;

  // Strict compares keep the earliest index on a tie with min1; the tied
  // value still lands in min2 because min1 <= min2 always holds.
  function automatic ldn_op_e ldn_classify(input int unsigned mag,
                                           input int unsigned min1,
                                           input int unsigned min2);
    if (mag < min1) return LDN_OP_NEW_MIN1;
    if (mag < min2) return LDN_OP_NEW_MIN2;
    return LDN_OP_KEEP;
  endfunction

endpackage

// File: rtl/ldn_mag_sat.sv
// Signed LLR to unsigned magnitude; the most-negative code saturates to the
// largest representable magnitude instead of wrapping to zero.
module ldn_mag_sat
  import ariane_pkg::*;
#(
  parameter int unsigned Q = LDN_Q
) (
  input  logic [Q-1:0] data,
  output logic [Q-2:0] mag
);

  localparam logic [Q-1:0] MOST_NEG = {1'b1, {(Q-1){1'b0}}};

  always_comb begin
    // NOTE: default assignment first so every path drives mag and no latch is inferred.
    mag = data[Q-2:0];
    if (data == MOST_NEG) begin
      mag = '1;
    end else if (data[Q-1]) begin
      mag = ~data[Q-2:0] + (Q-1)'(1);
    end
  end

endmodule

// File: rtl/ldn_cn_accum.sv
// Min-sum check-node accumulator: streams signed LLRs for one node and
// presents min1/min2/min1 index/sign parity/degree as a registered result.
module ldn_cn_accum
  import ariane_pkg::*;
#(
  parameter  int unsigned Q       = LDN_Q,
  parameter  int unsigned DEG_MAX = LDN_DEG_MAX,
  localparam int unsigned IDXW    = $clog2(DEG_MAX)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [Q-1:0]    data_i,
  input  logic            last_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [Q-2:0]    min1_o,
  output logic [Q-2:0]    min2_o,
  output logic [IDXW-1:0] min1_idx_o,
  output logic            sign_o,
  output logic [IDXW:0]   deg_o,
  output logic            ovf_o
);

  localparam logic [Q-2:0] MAG_MAX = '1;
  localparam logic [IDXW:0] DEG_LIMIT = (IDXW+1)'(DEG_MAX);

  ldn_state_e    state;
  logic [Q-2:0]  mag;
  ldn_op_e       op;
  logic [IDXW:0] count_next;
  logic          xfer;

  ldn_mag_sat #(.Q(Q)) u_mag_sat (
    .data (data_i),
    .mag  (mag)
  );

  assign xfer       = valid_i && ready_o;
  assign count_next = deg_o + (IDXW+1)'(1);

  always_comb begin
    op = ldn_classify(32'(mag), 32'(min1_o), 32'(min2_o));
  end

  // IDLE and ACC share one update path: the accumulators are already at their
  // cleared values in IDLE, so the first message needs no special load.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
    if (rst_i) begin
      state      <= LDN_IDLE;
      ready_o    <= 1'b1;
      valid_o    <= 1'b0;
      min1_o     <= MAG_MAX;
      min2_o     <= MAG_MAX;
      min1_idx_o <= '0;
      sign_o     <= 1'b0;
      deg_o      <= '0;
      ovf_o      <= 1'b0;
    end else begin
      case (state)
        LDN_IDLE, LDN_ACC: begin
          if (xfer) begin
            case (op)
              LDN_OP_NEW_MIN1: begin
                min2_o     <= min1_o;
                min1_o     <= mag;
                min1_idx_o <= deg_o[IDXW-1:0];
              end
              LDN_OP_NEW_MIN2: min2_o <= mag;
              default: ;
            endcase
            sign_o <= sign_o ^ data_i[Q-1];
            deg_o  <= count_next;
            if (last_i || (count_next == DEG_LIMIT)) begin
              state   <= LDN_OUT;
              ovf_o   <= !last_i;
              ready_o <= 1'b0;
              valid_o <= 1'b1;
            end else begin
              state <= LDN_ACC;
            end
          end
        end
        LDN_OUT: begin
          if (ready_i) begin
            state      <= LDN_IDLE;
            ready_o    <= 1'b1;
            valid_o    <= 1'b0;
            min1_o     <= MAG_MAX;
            min2_o     <= MAG_MAX;
            min1_idx_o <= '0;
            sign_o     <= 1'b0;
            deg_o      <= '0;
            ovf_o      <= 1'b0;
          end
        end
        default: begin
          state   <= LDN_IDLE;
          ready_o <= 1'b1;
          valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ldn_cn_accum.sv
// Directed and randomized check of ldn_cn_accum against a min-of-set model.
module tb_ldn_cn_accum;

  localparam int Q    = 8;
  localparam int IDXW = 5;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            valid_i;
  logic            ready_o;
  logic [Q-1:0]    data_i;
  logic            last_i;
  logic            valid_o;
  logic            ready_i;
  logic [Q-2:0]    min1_o;
  logic [Q-2:0]    min2_o;
  logic [IDXW-1:0] min1_idx_o;
  logic            sign_o;
  logic [IDXW:0]   deg_o;
  logic            ovf_o;

  ldn_cn_accum dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .data_i     (data_i),
    .last_i     (last_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .min1_o     (min1_o),
    .min2_o     (min2_o),
    .min1_idx_o (min1_idx_o),
    .sign_o     (sign_o),
    .deg_o      (deg_o),
    .ovf_o      (ovf_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  logic signed [7:0] nbuf [64];

  logic [7:0] str_d [128];
  bit         str_l [128];
  int         nstart [8];
  int         nlen   [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int mag_of(input logic signed [7:0] v);
    int x;
    x = int'(v);
    if (x < 0) x = -x;
    if (x > 127) x = 127;
    return x;
  endfunction

  function automatic logic [7:0] rand_llr();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return 8'h80;
    if (r == 1) return 8'h7f;
    if (r == 2) return 8'h00;
    return 8'($urandom_range(0, 255));
  endfunction

  // Model: min1 is the smallest magnitude at its first position, min2 the
  // smallest over all other positions (127 if none), sign the parity.
  task automatic expect_node(input int n, input bit exp_ovf, input string tag);
    int m1, m2, ix;
    bit sg;
    m1 = 128; ix = 0; sg = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (mag_of(nbuf[i]) < m1) begin
        m1 = mag_of(nbuf[i]);
        ix = i;
      end
      sg = sg ^ nbuf[i][7];
    end
    m2 = 127;
    for (int i = 0; i < n; i++) begin
      if (i != ix && mag_of(nbuf[i]) < m2) m2 = mag_of(nbuf[i]);
    end
    check({tag, ".valid"}, 32'(valid_o),    32'd1);
    check({tag, ".ready"}, 32'(ready_o),    32'd0);
    check({tag, ".min1"},  32'(min1_o),     m1);
    check({tag, ".min2"},  32'(min2_o),     m2);
    check({tag, ".idx"},   32'(min1_idx_o), ix);
    check({tag, ".sign"},  32'(sign_o),     32'(sg));
    check({tag, ".deg"},   32'(deg_o),      n);
    check({tag, ".ovf"},   32'(ovf_o),      32'(exp_ovf));
  endtask

  // Called at a negedge; returns at the negedge after the final transfer.
  task automatic send_msgs(input int n, input bit with_last, input string tag);
    for (int i = 0; i < n; i++) begin
      int guard;
      guard   = 0;
      data_i  = nbuf[i];
      last_i  = with_last && (i == n - 1);
      valid_i = 1'b1;
      while (!ready_o && guard < 50) begin
        @(negedge clk_i);
        guard++;
      end
      check({tag, ".accept_in_time"}, 32'(guard < 50), 32'd1);
      @(posedge clk_i);
      @(negedge clk_i);
    end
    valid_i = 1'b0;
    last_i  = 1'b0;
  endtask

  task automatic release_out(input string tag);
    ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    ready_i = 1'b0;
    check({tag, ".rel_valid"}, 32'(valid_o), 32'd0);
    check({tag, ".rel_ready"}, 32'(ready_o), 32'd1);
    check({tag, ".rel_deg"},   32'(deg_o),   32'd0);
    check({tag, ".rel_min1"},  32'(min1_o),  32'd127);
  endtask

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0; last_i = 1'b0; data_i = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    check("reset.ready", 32'(ready_o),    32'd1);
    check("reset.valid", 32'(valid_o),    32'd0);
    check("reset.min1",  32'(min1_o),     32'd127);
    check("reset.min2",  32'(min2_o),     32'd127);
    check("reset.idx",   32'(min1_idx_o), 32'd0);
    check("reset.sign",  32'(sign_o),     32'd0);
    check("reset.deg",   32'(deg_o),      32'd0);
    check("reset.ovf",   32'(ovf_o),      32'd0);

    // Ties between equal magnitudes: earliest index kept, min2 takes the tie.
    nbuf[0] = 8'sd5; nbuf[1] = -8'sd3; nbuf[2] = 8'sd7; nbuf[3] = -8'sd3;
    send_msgs(4, 1'b1, "tie");
    expect_node(4, 1'b0, "tie");
    check("tie.min1_const", 32'(min1_o), 32'd3);
    check("tie.min2_const", 32'(min2_o), 32'd3);
    release_out("tie");

    // Degree-1 node with the saturating most-negative input.
    nbuf[0] = -8'sd128;
    send_msgs(1, 1'b1, "deg1");
    expect_node(1, 1'b0, "deg1");
    release_out("deg1");

    // Overflow: DEG_MAX messages with no last.
    for (int i = 0; i < 32; i++) nbuf[i] = 8'sd10;
    send_msgs(32, 1'b0, "ovf");
    expect_node(32, 1'b1, "ovf");

    // Hold the result with the consumer stalled while upstream keeps offering.
    valid_i = 1'b1; data_i = 8'hec; last_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check("hold.ready", 32'(ready_o), 32'd0);
      check("hold.valid", 32'(valid_o), 32'd1);
      check("hold.deg",   32'(deg_o),   32'd32);
      check("hold.min1",  32'(min1_o),  32'd10);
      check("hold.ovf",   32'(ovf_o),   32'd1);
      @(posedge clk_i);
      @(negedge clk_i);
    end
    ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    ready_i = 1'b0;
    check("hold.idle_valid", 32'(valid_o), 32'd0);
    check("hold.idle_ready", 32'(ready_o), 32'd1);
    check("hold.idle_deg",   32'(deg_o),   32'd0);
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0; last_i = 1'b0;
    nbuf[0] = -8'sd20;
    expect_node(1, 1'b0, "resume");
    release_out("resume");

    // Reset in the middle of a node discards it.
    nbuf[0] = 8'sd9; nbuf[1] = -8'sd4; nbuf[2] = 8'sd6; nbuf[3] = 8'sd1;
    send_msgs(2, 1'b0, "midrst");
    rst_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    check("midrst.valid", 32'(valid_o), 32'd0);
    check("midrst.ready", 32'(ready_o), 32'd1);
    check("midrst.deg",   32'(deg_o),   32'd0);
    check("midrst.min1",  32'(min1_o),  32'd127);
    check("midrst.sign",  32'(sign_o),  32'd0);
    repeat (3) @(negedge clk_i);
    check("midrst.valid_later", 32'(valid_o), 32'd0);
    nbuf[0] = -8'sd1; nbuf[1] = 8'sd2;
    send_msgs(2, 1'b1, "after_rst");
    expect_node(2, 1'b0, "after_rst");
    check("after_rst.min2_const", 32'(min2_o), 32'd2);
    release_out("after_rst");

    // Back-to-back random nodes with valid_i and ready_i held high.
    begin
      int total, ptr, k, gaps, cyc;
      bit expect_out, accepted;
      total = 0;
      for (int n = 0; n < 6; n++) begin
        nstart[n] = total;
        nlen[n]   = int'($urandom_range(1, 8));
        for (int j = 0; j < nlen[n]; j++) begin
          str_d[total] = rand_llr();
          str_l[total] = (j == nlen[n] - 1);
          total++;
        end
      end
      ptr = 0; k = 0; gaps = 0; cyc = 0; expect_out = 1'b0;
      ready_i = 1'b1;
      while (k < 6 && cyc < 500) begin
        if (ptr < total) begin
          valid_i = 1'b1; data_i = str_d[ptr]; last_i = str_l[ptr];
        end else begin
          valid_i = 1'b0; last_i = 1'b0;
        end
        if (expect_out) begin
          for (int j = 0; j < nlen[k]; j++) nbuf[j] = str_d[nstart[k] + j];
          expect_node(nlen[k], 1'b0, "b2b");
          k++;
          expect_out = 1'b0;
        end
        if (ptr < total && !ready_o) gaps++;
        accepted = ready_o && valid_i;
        @(posedge clk_i);
        if (accepted) begin
          if (str_l[ptr]) expect_out = 1'b1;
          ptr++;
        end
        @(negedge clk_i);
        cyc++;
      end
      valid_i = 1'b0; last_i = 1'b0; ready_i = 1'b0;
      check("b2b.all_nodes", k, 6);
      check("b2b.gaps", gaps, 5);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
